keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of the 4x4 hex keypad as seen from the keypad connector: it answers the decoder's column scan on the row lines.
- Accepts a 16-bit value over a valid/ready handshake and "presses" its four hex digits MSB-first, each held for a fixed time, then released for a gap.
- Used for on-board self-test and automated play of the memorization game in place of the physical keypad; sits between the sequence source and the keyboard decoder's cols/rows pins.

Parameters:
- HOLD_CYCLES, 2000000, clocks each digit is held pressed (20 ms at 100 MHz); must be >= 1.
- GAP_CYCLES, 2000000, clocks of full release after each digit, including the last; must be >= 1.
- CNT_W, 32, width of the internal hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset.
- cols, input, 4, column strobes from the decoder; active-low, one column low at a time.
- rows, output, 4, emulated row lines; active-low; 4'hF means no key.
- seq_value, input, 16, four hex digits; [15:12] are pressed first.
- seq_valid, input, 1, request to play seq_value.
- seq_ready, output, 1, high only in IDLE; a transfer occurs when seq_valid && seq_ready.
- busy, output, 1, high in PRESS or GAP.
- digit_idx, output, 2, index of the digit currently pressed or gapped; 0 = [15:12].
- seq_done, output, 1, one-clock pulse when the final gap completes.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rows=4'hF, seq_ready=1, busy=0, digit_idx=0, seq_done=0, counter=0.
  - The latched value is cleared.
  - Reset mid-sequence aborts immediately. No partial press survives, and seq_done does not fire.
- Key map, row r / column c, c=0 leftmost:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- IDLE:
  - rows=4'hF, seq_ready=1.
  - On seq_valid && seq_ready: latch seq_value, digit_idx=0, counter=0, go to PRESS next clock. seq_ready drops that same edge.
- PRESS:
  - Active digit = latched nibble at digit_idx; it maps to (r,c).
  - Each clock, registered: rows <= (cols == ~(4'b1<<c)) ? ~(4'b1<<r) : 4'hF.
  - Row response lags cols by exactly 1 clock.
  - Any cols pattern that is not exactly one zero (all high, or several low) drives rows=4'hF.
  - Counter increments each clock. After HOLD_CYCLES clocks in PRESS, go to GAP with counter=0.
- GAP:
  - rows=4'hF (registered, so it takes effect on the clock after entering GAP).
  - After GAP_CYCLES clocks:
    - If digit_idx<3: digit_idx+1, go to PRESS.
    - Otherwise: seq_done=1 for one clock, digit_idx=0, go to IDLE.
- Total sequence length is 4*(HOLD_CYCLES+GAP_CYCLES) clocks from handshake to seq_done.
- seq_valid is ignored while busy. A new handshake is accepted the clock after seq_done, since seq_ready is high in IDLE.
- seq_value changes after the handshake have no effect.
- Repeated digits (e.g. 16'h1111) are separated by a GAP, so the decoder sees four distinct presses.
- The counter never wraps; it is reset to 0 at every state transition.
- busy = (state != IDLE). seq_ready = (state == IDLE). Both are derived combinationally from registered state.

Test Plan:
Use HOLD_CYCLES=8, GAP_CYCLES=4, and a bench column scanner stepping cols through E,D,B,7 every clock.
- Reset values: hold rst low mid-PRESS on 16'h1234 -> rows=F, seq_ready=1, busy=0 within the same clock; no seq_done afterwards.
- Mapping: play 16'h5A0D -> digit 5 pulls rows=D only the clock after cols=D; A gives rows=E after cols=7; 0 gives rows=7 after cols=E; D gives rows=7 after cols=7.
- Timing: play 16'h1234 -> busy high for exactly 48 clocks, seq_done a single pulse at clock 48, digit_idx steps 0,1,2,3.
- Handshake: seq_valid held high with 16'hFFFF then 16'h0000 -> first value played fully; second accepted only the clock after seq_done.
- Bad scan: cols=F, then cols=C during PRESS of digit 1 -> rows=F.
- Repeats: play 16'h1111 -> rows returns to F for 4 clocks between each of four presses.

Source files
------------

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 hex keypad on the decoder's row lines: plays the four hex digits of a
// 16-bit value MSB-first, each pressed for HOLD_CYCLES and then released for GAP_CYCLES.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 2000000,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    input  logic [15:0] seq_value,
    input  logic        seq_valid,
    output logic        seq_ready,
    output logic        busy,
    output logic [1:0]  digit_idx,
    output logic        seq_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [15:0]      r_value;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [1:0]       r_idx;
    logic [1:0]       w_nextIdx;
    logic [3:0]       r_rows;
    logic [3:0]       w_nextRows;
    logic             r_done;
    logic             w_nextDone;
    logic             w_accept;
    logic [3:0]       w_nibble;
    logic [1:0]       w_keyRow;
    logic [1:0]       w_keyCol;

    assign w_accept = seq_valid && (r_state == S_IDLE);

    always_comb begin
        w_nibble = r_value[15:12];
        case (r_idx)
            2'd0: w_nibble = r_value[15:12];
            2'd1: w_nibble = r_value[11:8];
            2'd2: w_nibble = r_value[7:4];
            2'd3: w_nibble = r_value[3:0];
            default: w_nibble = r_value[15:12];
        endcase
    end

    // Physical key position of the active digit: {row, column}, column 0 leftmost.
    always_comb begin
        {w_keyRow, w_keyCol} = 4'b0000;
        case (w_nibble)
            4'h1: {w_keyRow, w_keyCol} = {2'd0, 2'd0};
            4'h2: {w_keyRow, w_keyCol} = {2'd0, 2'd1};
            4'h3: {w_keyRow, w_keyCol} = {2'd0, 2'd2};
            4'hA: {w_keyRow, w_keyCol} = {2'd0, 2'd3};
            4'h4: {w_keyRow, w_keyCol} = {2'd1, 2'd0};
            4'h5: {w_keyRow, w_keyCol} = {2'd1, 2'd1};
            4'h6: {w_keyRow, w_keyCol} = {2'd1, 2'd2};
            4'hB: {w_keyRow, w_keyCol} = {2'd1, 2'd3};
            4'h7: {w_keyRow, w_keyCol} = {2'd2, 2'd0};
            4'h8: {w_keyRow, w_keyCol} = {2'd2, 2'd1};
            4'h9: {w_keyRow, w_keyCol} = {2'd2, 2'd2};
            4'hC: {w_keyRow, w_keyCol} = {2'd2, 2'd3};
            4'h0: {w_keyRow, w_keyCol} = {2'd3, 2'd0};
            4'hF: {w_keyRow, w_keyCol} = {2'd3, 2'd1};
            4'hE: {w_keyRow, w_keyCol} = {2'd3, 2'd2};
            default: {w_keyRow, w_keyCol} = {2'd3, 2'd3};
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt + 1'b1;
        w_nextIdx   = r_idx;
        w_nextRows  = 4'hF;
        w_nextDone  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextCnt = '0;
                if (w_accept) begin
                    w_nextState = S_PRESS;
                    w_nextIdx   = 2'd0;
                end
            end
            S_PRESS: begin
                // Only an exact single-column strobe on our column closes the switch.
                if (cols == ~(4'b0001 << w_keyCol)) begin
                    w_nextRows = ~(4'b0001 << w_keyRow);
                end
                if (r_cnt == HOLD_LAST) begin
                    w_nextState = S_GAP;
                    w_nextCnt   = '0;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_nextCnt = '0;
                    if (r_idx == 2'd3) begin
                        w_nextState = S_IDLE;
                        w_nextIdx   = 2'd0;
                        w_nextDone  = 1'b1;
                    end else begin
                        w_nextState = S_PRESS;
                        w_nextIdx   = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextCnt   = '0;
                w_nextIdx   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_value <= 16'h0000;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_rows  <= 4'hF;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
            r_rows  <= w_nextRows;
            r_done  <= w_nextDone;
            if (w_accept) begin
                r_value <= seq_value;
            end
        end
    end

    assign rows      = r_rows;
    assign seq_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign digit_idx = r_idx;
    assign seq_done  = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed sequences plus random traffic, all
// compared each clock against a timeline-based keypad model.
module tb_keypad_emulator;

    localparam int HOLD      = 8;
    localparam int GAP       = 4;
    localparam int DIGIT_LEN = HOLD + GAP;
    localparam int SEQ_LEN   = 4 * DIGIT_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols = 4'hF;
    logic [3:0]  rows;
    logic [15:0] seqValue = 16'h0000;
    logic        seqValid = 1'b0;
    logic        seqReady;
    logic        busy;
    logic [1:0]  digitIdx;
    logic        seqDone;

    int compared   = 0;
    int mismatched = 0;

    // Model: position in the 48-clock timeline of the current sequence.
    bit          mActive = 1'b0;
    int          mK      = 0;
    logic [15:0] mVal    = 16'h0000;
    logic [3:0]  mRows   = 4'hF;
    bit          mDone   = 1'b0;
    int          keyRow[16];
    int          keyCol[16];
    logic [3:0]  keyMap[4][4];

    logic [3:0]  scanPat[4];
    int          scanPhase = 0;
    bit          scanFixed = 1'b0;
    logic [3:0]  fixedCols = 4'hF;
    int          busyRun   = 0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cols     (cols),
        .rows     (rows),
        .seq_value(seqValue),
        .seq_valid(seqValid),
        .seq_ready(seqReady),
        .busy     (busy),
        .digit_idx(digitIdx),
        .seq_done (seqDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mActive = 1'b0;
        mK      = 0;
        mRows   = 4'hF;
        mDone   = 1'b0;
    endtask

    // Predicts the outputs after the coming clock edge from the inputs presented to it.
    task automatic modelEdge();
        int d;
        logic [3:0] nib;
        if (!rst) begin
            modelReset();
            return;
        end
        mDone = 1'b0;
        if (!mActive) begin
            mRows = 4'hF;
            if (seqValid) begin
                mActive = 1'b1;
                mVal    = seqValue;
                mK      = 0;
            end
        end else begin
            d   = mK / DIGIT_LEN;
            nib = 4'((mVal >> (4 * (3 - d))) & 16'h000F);
            if ((mK % DIGIT_LEN) < HOLD && cols == ~(4'(1) << keyCol[nib]))
                mRows = ~(4'(1) << keyRow[nib]);
            else
                mRows = 4'hF;
            mK++;
            if (mK == SEQ_LEN) begin
                mActive = 1'b0;
                mDone   = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("rows", 32'(rows), 32'(mRows));
        checkOutput("busy", 32'(busy), 32'(mActive));
        checkOutput("seq_ready", 32'(seqReady), 32'(!mActive));
        checkOutput("digit_idx", 32'(digitIdx), mActive ? 32'(mK / DIGIT_LEN) : 32'd0);
        checkOutput("seq_done", 32'(seqDone), 32'(mDone));
        if (busy) begin
            busyRun++;
        end else begin
            if (seqDone) checkOutput("busy_len", 32'(busyRun), 32'(SEQ_LEN));
            busyRun = 0;
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (scanFixed) begin
                cols = fixedCols;
            end else begin
                cols      = scanPat[scanPhase];
                scanPhase = (scanPhase + 1) % 4;
            end
            modelEdge();
            @(posedge clk);
            #1;
            checkAll();
        end
    endtask

    task automatic playSequence(input logic [15:0] v);
        seqValue = v;
        seqValid = 1'b1;
        applyStimulus(1);
        seqValid = 1'b0;
        seqValue = 16'($urandom);
        applyStimulus(SEQ_LEN + 3);
    endtask

    initial begin
        keyMap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                   '{4'h4, 4'h5, 4'h6, 4'hB},
                   '{4'h7, 4'h8, 4'h9, 4'hC},
                   '{4'h0, 4'hF, 4'hE, 4'hD}};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                keyRow[keyMap[r][c]] = r;
                keyCol[keyMap[r][c]] = c;
            end
        end
        scanPat = '{4'hE, 4'hD, 4'hB, 4'h7};

        #2 rst = 1'b0;
        #2 modelReset();
        checkAll();
        @(posedge clk);
        #1;
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(2);

        // Abort mid-press: outputs must clear without waiting for a clock.
        seqValue = 16'h1234;
        seqValid = 1'b1;
        applyStimulus(1);
        seqValid = 1'b0;
        applyStimulus(5);
        rst = 1'b0;
        #1 modelReset();
        checkAll();
        applyStimulus(3);
        rst = 1'b1;
        applyStimulus(SEQ_LEN + 5);

        playSequence(16'h5A0D);
        playSequence(16'h1234);

        // Handshake held high across two values.
        seqValue = 16'hFFFF;
        seqValid = 1'b1;
        applyStimulus(1);
        seqValue = 16'h0000;
        applyStimulus(SEQ_LEN + 4);
        seqValid = 1'b0;
        applyStimulus(SEQ_LEN + 2);

        // Malformed column scans during a press of digit 1.
        seqValue = 16'h1000;
        seqValid = 1'b1;
        applyStimulus(1);
        seqValid  = 1'b0;
        scanFixed = 1'b1;
        fixedCols = 4'hF;
        applyStimulus(2);
        fixedCols = 4'hC;
        applyStimulus(2);
        fixedCols = 4'hE;
        applyStimulus(2);
        fixedCols = 4'h0;
        applyStimulus(1);
        scanFixed = 1'b0;
        applyStimulus(SEQ_LEN);

        playSequence(16'h1111);

        for (int i = 0; i < 400; i++) begin
            seqValid  = ($urandom % 4) == 0;
            seqValue  = 16'($urandom);
            scanFixed = ($urandom % 5) == 0;
            fixedCols = 4'($urandom);
            applyStimulus(1);
        end
        seqValid  = 1'b0;
        scanFixed = 1'b0;
        applyStimulus(SEQ_LEN + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
